saes_key_expand: RTL and testbench
==================================

// Module: saes_key_expand
// PURPOSE
//   Sequential key-expansion stage for the 16-bit Simplified-AES core.
//   Takes a 16-bit cipher key plus an operation bit and produces the three
//   round keys K0, K1, K2 over several cycles.
//   Sits directly upstream of the S-AES round datapath and feeds it a
//   round-key set, ordered for encrypt or decrypt, through a valid/ack handshake.
// PARAMETERS
//   RCON1  8'h80  round constant XORed into w2
//   RCON2  8'h30  round constant XORed into w4
// PORTS
//   clk        in   1   single clock, all state changes on rising edge
//   rst        in   1   synchronous, active-high reset
//   key        in   16  cipher key; w0=key[15:8], w1=key[7:0]
//   operation  in   1   1=encrypt, 0=decrypt; captured together with key
//   key_valid  in   1   key/operation presented
//   key_ready  out  1   block can accept a key (state IDLE)
//   rk_first   out  16  first-round key (enc: K0, dec: K2)
//   rk_mid     out  16  middle-round key (K1 in both modes)
//   rk_last    out  16  last-round key (enc: K2, dec: K0)
//   op_out     out  1   captured operation bit, aligned with the round keys
//   rk_valid   out  1   round-key set complete and stable
//   rk_ack     in   1   consumer has taken the round-key set
// BEHAVIOUR
//   Reset: state=IDLE, key_ready=1, rk_valid=0, rk_first/mid/last=16'h0000,
//   op_out=0, internal w0..w5=0.
//   SubNib S-box, input nibble 0..F -> 9 4 A B D 1 8 5 6 2 0 3 C E F 7.
//   RotNib(b) swaps the nibbles of a byte. g(b) = SubNib(RotNib(b)).
//   Arithmetic: all operations are 8-bit XOR; there is no carry or width growth.
//   FSM: IDLE -> R1 -> R2 -> DONE -> IDLE.
//     IDLE: key_ready=1. On key_valid&&key_ready, latch w0, w1 and op; go to R1.
//           key_valid with no handshake has no effect.
//     R1:   w2 = w0^RCON1^g(w1); w3 = w2^w1; go to R2. key_ready=0.
//     R2:   w4 = w2^RCON2^g(w3); w5 = w4^w3. Load the outputs with
//           K0={w0,w1}, K1={w2,w3}, K2={w4,w5}, ordered by op. Set rk_valid=1.
//           Go to DONE.
//     DONE: rk_valid=1. Outputs are held stable while rk_ack=0.
//           On rk_ack=1: rk_valid=0 next cycle, go to IDLE.
//   Latency: handshake in cycle C -> rk_valid=1 in cycle C+3.
//   Throughput: one key set per 4 cycles when rk_ack is tied high.
//   After ack, rk_* and op_out keep their last values until the next R2 load.
//   key_valid while busy (R1/R2/DONE): ignored. The key is not queued.
//   rk_ack outside DONE: ignored.
//   rst during any state: rst has priority over every other input.
//     Return to the reset values on the next edge. Any in-flight expansion is
//     discarded and rk_valid never pulses for it.
//   key_valid and rst asserted together: rst wins, no capture.
// TESTING
//   1. key=16'h4AF5, operation=1 -> C+3: rk_first=4AF5, rk_mid=DD28,
//      rk_last=87AF, op_out=1, rk_valid=1.
//   2. key=16'hA73B, operation=1 -> rk_first=A73B, rk_mid=1C27, rk_last=7651.
//      Repeat with operation=0 -> rk_first=7651, rk_mid=1C27, rk_last=A73B,
//      op_out=0.
//   3. Hold rk_ack=0 for 10 cycles in DONE -> outputs and rk_valid stable.
//      Pulse rk_ack -> rk_valid=0 and key_ready=1 the next cycle.
//   4. Present key=16'h1234 during R1 and during DONE -> no capture; outputs
//      still reflect the first key; key_ready=0 throughout.
//   5. Assert rst in R2 -> next cycle all outputs are 0 and key_ready=1;
//      rk_valid never asserts.
//   6. rk_ack tied 1, back-to-back keys 4AF5 then A73B -> rk_valid pulses for
//      one cycle each, 4 cycles apart, with the values from tests 1 and 2.

Source files
------------

// File: rtl/saes_key_expand.sv
// ----------------------------------------------------------------------------
// saes_key_expand
//   Sequential key expansion for the 16-bit Simplified-AES core. A 16-bit
//   cipher key and an operation bit are captured through a valid/ready
//   handshake. The three round keys K0, K1 and K2 are then derived over two
//   cycles. They are presented to the round datapath in encrypt or decrypt
//   order and held under a valid/ack handshake.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset, highest priority
//   key        in   16  cipher key, w0 = key[15:8], w1 = key[7:0]
//   operation  in   1   1 = encrypt, 0 = decrypt, captured with key
//   key_valid  in   1   key/operation presented
//   key_ready  out  1   block can accept a key (IDLE)
//   rk_first   out  16  first-round key (enc: K0, dec: K2)
//   rk_mid     out  16  middle-round key (K1)
//   rk_last    out  16  last-round key (enc: K2, dec: K0)
//   op_out     out  1   captured operation bit, aligned with the round keys
//   rk_valid   out  1   round-key set complete and stable
//   rk_ack     in   1   consumer has taken the round-key set
// ----------------------------------------------------------------------------
module saes_key_expand #(
    parameter logic [7:0] RCON1 = 8'h80,
    parameter logic [7:0] RCON2 = 8'h30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key,
    input  logic        operation,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [15:0] rk_first,
    output logic [15:0] rk_mid,
    output logic [15:0] rk_last,
    output logic        op_out,
    output logic        rk_valid,
    input  logic        rk_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_R1   = 2'd1,
        S_R2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // 4-bit S-box, applied to each nibble independently.
    function automatic logic [3:0] sub_nib(input logic [3:0] n);
        logic [3:0] s;
        // NOTE: the output gets a value on every path, and the case has a
        // default. This keeps the logic purely combinational.
        s = 4'h0;
        case (n)
            4'h0: s = 4'h9;
            4'h1: s = 4'h4;
            4'h2: s = 4'hA;
            4'h3: s = 4'hB;
            4'h4: s = 4'hD;
            4'h5: s = 4'h1;
            4'h6: s = 4'h8;
            4'h7: s = 4'h5;
            4'h8: s = 4'h6;
            4'h9: s = 4'h2;
            4'hA: s = 4'h0;
            4'hB: s = 4'h3;
            4'hC: s = 4'hC;
            4'hD: s = 4'hE;
            4'hE: s = 4'hF;
            default: s = 4'h7;
        endcase
        return s;
    endfunction

    // g(b) = SubNib(RotNib(b)). The rotation is folded into the nibble select.
    function automatic logic [7:0] g_fn(input logic [7:0] b);
        return {sub_nib(b[3:0]), sub_nib(b[7:4])};
    endfunction

    state_t      r_state;
    logic [7:0]  r_w0, r_w1, r_w2, r_w3;
    logic        r_op;
    logic        r_key_ready;
    logic        r_rk_valid;
    logic [15:0] r_rk_first, r_rk_mid, r_rk_last;
    logic        r_op_out;

    // Round 1 words come from the captured key. Round 2 words come from the
    // round 1 registers. w4/w5 go straight into the output registers, so they
    // need no storage of their own.
    logic [7:0] w_w2, w_w3, w_w4, w_w5;
    assign w_w2 = r_w0 ^ RCON1 ^ g_fn(r_w1);
    assign w_w3 = w_w2 ^ r_w1;
    assign w_w4 = r_w2 ^ RCON2 ^ g_fn(r_w3);
    assign w_w5 = w_w4 ^ r_w3;

    always_ff @(posedge clk) begin
        // NOTE: the key words are cleared on reset along with the control
        // state. This way no stale key material survives a reset.
        if (rst) begin
            r_state     <= S_IDLE;
            r_w0        <= 8'h00;
            r_w1        <= 8'h00;
            r_w2        <= 8'h00;
            r_w3        <= 8'h00;
            r_op        <= 1'b0;
            r_key_ready <= 1'b1;
            r_rk_valid  <= 1'b0;
            r_rk_first  <= 16'h0000;
            r_rk_mid    <= 16'h0000;
            r_rk_last   <= 16'h0000;
            r_op_out    <= 1'b0;
        end else begin
            // NOTE: every state update is non-blocking. All registers therefore
            // see the values from before this edge.
            case (r_state)
                S_IDLE: begin
                    if (key_valid && r_key_ready) begin
                        r_w0        <= key[15:8];
                        r_w1        <= key[7:0];
                        r_op        <= operation;
                        r_key_ready <= 1'b0;
                        r_state     <= S_R1;
                    end
                end
                S_R1: begin
                    r_w2    <= w_w2;
                    r_w3    <= w_w3;
                    r_state <= S_R2;
                end
                S_R2: begin
                    // The encrypt order is K0, K1, K2. Decrypt uses the same
                    // keys reversed.
                    r_rk_mid <= {r_w2, r_w3};
                    if (r_op) begin
                        r_rk_first <= {r_w0, r_w1};
                        r_rk_last  <= {w_w4, w_w5};
                    end else begin
                        r_rk_first <= {w_w4, w_w5};
                        r_rk_last  <= {r_w0, r_w1};
                    end
                    r_op_out   <= r_op;
                    r_rk_valid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (rk_ack) begin
                        r_rk_valid  <= 1'b0;
                        r_key_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rk_valid  <= 1'b0;
                    r_key_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign key_ready = r_key_ready;
    assign rk_first  = r_rk_first;
    assign rk_mid    = r_rk_mid;
    assign rk_last   = r_rk_last;
    assign op_out    = r_op_out;
    assign rk_valid  = r_rk_valid;

endmodule

// File: tb/tb_saes_key_expand.sv
// ----------------------------------------------------------------------------
// tb_saes_key_expand
//   Self-checking bench for saes_key_expand. Expected round keys come from an
//   arithmetic model of the S-AES key schedule. The bench tracks the values
//   the outputs must hold between key loads.
// ----------------------------------------------------------------------------
module tb_saes_key_expand;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key;
    logic        operation;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] rk_first, rk_mid, rk_last;
    logic        op_out;
    logic        rk_valid;
    logic        rk_ack;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Round-key values the outputs must currently hold.
    logic [15:0] m_first = 16'h0, m_mid = 16'h0, m_last = 16'h0;
    logic        m_op    = 1'b0;

    int sbox [16] = '{9, 4, 10, 11, 13, 1, 8, 5, 6, 2, 0, 3, 12, 14, 15, 7};

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    saes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .operation (operation),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_first  (rk_first),
        .rk_mid    (rk_mid),
        .rk_last   (rk_last),
        .op_out    (op_out),
        .rk_valid  (rk_valid),
        .rk_ack    (rk_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // g(b): swap nibbles, then substitute each. After the swap, the high
    // nibble is b mod 16 and the low nibble is b div 16.
    function automatic int g_ref(input int b);
        return sbox[b % 16] * 16 + sbox[b / 16];
    endfunction

    // Returns {K0, K1, K2}.
    function automatic logic [47:0] expand_ref(input logic [15:0] k);
        int w0, w1, w2, w3, w4, w5;
        w0 = int'(k) / 256;
        w1 = int'(k) % 256;
        w2 = w0 ^ 'h80 ^ g_ref(w1);
        w3 = w2 ^ w1;
        w4 = w2 ^ 'h30 ^ g_ref(w3);
        w5 = w4 ^ w3;
        return {16'(w0 * 256 + w1), 16'(w2 * 256 + w3), 16'(w4 * 256 + w5)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic exp_valid, input logic exp_ready);
        check({tag, "_first"}, 32'(rk_first), 32'(m_first));
        check({tag, "_mid"},   32'(rk_mid),   32'(m_mid));
        check({tag, "_last"},  32'(rk_last),  32'(m_last));
        check({tag, "_op"},    32'(op_out),   32'(m_op));
        check({tag, "_valid"}, 32'(rk_valid), 32'(exp_valid));
        check({tag, "_ready"}, 32'(key_ready), 32'(exp_ready));
    endtask

    // Runs one key through the block, starting in IDLE. hold is the number of
    // extra DONE cycles with rk_ack low. poke drives a junk key while the block
    // is busy. ack_early raises rk_ack at the handshake. It stays high on
    // return, so the next call presents the following key back-to-back.
    task automatic run_key(input logic [15:0] k, input logic op, input int hold,
                           input logic poke, input logic ack_early, output int done_cycle);
        logic [47:0] ks;
        ks = expand_ref(k);
        key       = k;
        operation = op;
        key_valid = 1'b1;
        if (ack_early) rk_ack = 1'b1;
        tick();                               // R1
        key_valid = poke;
        key       = 16'h1234;
        operation = ~op;
        check_state("r1", 1'b0, 1'b0);
        tick();                               // R2
        check_state("r2", 1'b0, 1'b0);
        tick();                               // DONE, C+3
        done_cycle = cycle;
        m_first = op ? ks[47:32] : ks[15:0];
        m_mid   = ks[31:16];
        m_last  = op ? ks[15:0]  : ks[47:32];
        m_op    = op;
        check_state("done", 1'b1, 1'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_state("hold", 1'b1, 1'b0);
        end
        rk_ack = 1'b1;
        tick();                               // back to IDLE
        key_valid = 1'b0;
        check_state("ack", 1'b0, 1'b1);
        if (!ack_early) begin
            rk_ack = 1'b0;
            tick();                           // a busy-time key must not be captured
            check_state("idle", 1'b0, 1'b1);
        end
    endtask

    initial begin
        int t_a, t_b;
        rst = 1'b1; key = 16'h0; operation = 1'b0; key_valid = 1'b0; rk_ack = 1'b0;
        tick();
        tick();
        check_state("reset", 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        check_state("post_reset", 1'b0, 1'b1);

        // Known-answer vectors
        run_key(16'h4AF5, 1'b1, 0, 1'b0, 1'b0, t_a);
        check("kat1_first", 32'(rk_first), 32'h4AF5);
        check("kat1_mid",   32'(rk_mid),   32'hDD28);
        check("kat1_last",  32'(rk_last),  32'h87AF);
        run_key(16'hA73B, 1'b1, 0, 1'b0, 1'b0, t_a);
        check("kat2e_first", 32'(rk_first), 32'hA73B);
        check("kat2e_mid",   32'(rk_mid),   32'h1C27);
        check("kat2e_last",  32'(rk_last),  32'h7651);
        run_key(16'hA73B, 1'b0, 0, 1'b0, 1'b0, t_a);
        check("kat2d_first", 32'(rk_first), 32'h7651);
        check("kat2d_last",  32'(rk_last),  32'hA73B);
        check("kat2d_op",    32'(op_out),   32'h0);

        // Long hold in DONE, with a key presented while busy
        run_key(16'h4AF5, 1'b1, 10, 1'b1, 1'b0, t_a);
        check("busy_key_ignored", 32'(rk_first), 32'h4AF5);

        // rk_ack raised outside DONE is ignored, and pulses come back-to-back
        run_key(16'h4AF5, 1'b1, 0, 1'b0, 1'b1, t_a);
        run_key(16'hA73B, 1'b1, 0, 1'b0, 1'b1, t_b);
        check("b2b_spacing", 32'(t_b - t_a), 32'd4);
        check("b2b_last", 32'(rk_last), 32'h7651);
        rk_ack = 1'b0;
        tick();
        check_state("b2b_idle", 1'b0, 1'b1);

        // Reset asserted in R2 discards the expansion
        key = 16'($urandom); operation = 1'b1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_first = 16'h0; m_mid = 16'h0; m_last = 16'h0; m_op = 1'b0;
        check_state("rst_r2", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state("rst_r2_after", 1'b0, 1'b1);
        end

        // Reset takes priority over a key presented in the same cycle
        key = 16'hBEEF; operation = 1'b1; key_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; key_valid = 1'b0;
        check_state("rst_kv", 1'b0, 1'b1);
        tick();
        check_state("rst_kv_after", 1'b0, 1'b1);

        // Random keys, modes, hold times and busy-time pokes
        for (int n = 0; n < 24; n++) begin
            run_key(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, t_a);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
